// File: rtl/wb_port_arbiter_pkg.sv
// wb_port_arbiter_pkg: shared widths and the write-request record for the register-file write-port arbiter
package wb_port_arbiter_pkg;
    localparam int WORD = 32;
    localparam int W_RD = 5;
    typedef struct packed {
        logic [W_RD-1:0] num;
        logic [WORD-1:0] data;
    } wr_req_t;
endpackage

// File: rtl/wb_port_arbiter_if.sv
// wb_port_arbiter_if: producer/register-file side signals of the arbiter; perf outputs exist only under WB_ARB_PERF_EN
interface wb_port_arbiter_if;
    import wb_port_arbiter_pkg::*;
    logic            a_v_i;
    logic            a_wb_i;
    logic [W_RD-1:0] a_rd_num_i;
    logic [WORD-1:0] a_rd_data_i;
    logic            a_stall_o;
    logic            b_v_i;
    logic [W_RD-1:0] b_rd_num_i;
    logic [WORD-1:0] b_rd_data_i;
    logic            b_stall_o;
    logic            b_busy_o;
    logic            wb_o;
    logic [W_RD-1:0] wbr_num_o;
    logic [WORD-1:0] wb_data_o;
`ifdef WB_ARB_PERF_EN
    logic [31:0]     perf_a_stall_o;
    logic [31:0]     perf_b_full_o;
`endif
    modport master (
        output a_v_i, a_wb_i, a_rd_num_i, a_rd_data_i, b_v_i, b_rd_num_i, b_rd_data_i,
        input  a_stall_o, b_stall_o, b_busy_o, wb_o, wbr_num_o, wb_data_o
`ifdef WB_ARB_PERF_EN
        , input perf_a_stall_o, perf_b_full_o
`endif
    );
    modport slave (
        input  a_v_i, a_wb_i, a_rd_num_i, a_rd_data_i, b_v_i, b_rd_num_i, b_rd_data_i,
        output a_stall_o, b_stall_o, b_busy_o, wb_o, wbr_num_o, wb_data_o
`ifdef WB_ARB_PERF_EN
        , output perf_a_stall_o, perf_b_full_o
`endif
    );
endinterface

// File: rtl/wb_arb_fifo.sv
// wb_arb_fifo: power-of-two circular sync FIFO of write requests with head, full and empty
module wb_arb_fifo
    import wb_port_arbiter_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic    clk,
    input  logic    rst,
    input  logic    push,
    input  logic    pop,
    input  wr_req_t din,
    output logic    full,
    output logic    empty,
    output wr_req_t head
);
    localparam int AW = $clog2(DEPTH);
    logic [AW-1:0] wp, rp;
    logic [AW:0]   cnt;
    wr_req_t       mem [DEPTH];
    assign full  = cnt == (AW+1)'(DEPTH);
    assign empty = cnt == '0;
    assign head  = mem[rp];
    always_ff @(posedge clk)
        if (push) mem[wp] <= din;
    always_ff @(posedge clk) begin
        if (rst) begin
            wp  <= '0;
            rp  <= '0;
            cnt <= '0;
        end else begin
            wp  <= wp + AW'(push);
            rp  <= rp + AW'(pop);
            cnt <= cnt + (AW+1)'(push) - (AW+1)'(pop);
        end
    end
endmodule

// File: rtl/wb_port_arbiter.sv
// wb_port_arbiter: shares the register-file write port between A (priority) and FIFO-buffered B; WB_ARB_PERF_EN adds stall counters
module wb_port_arbiter
    import wb_port_arbiter_pkg::*;
#(
    parameter int B_DEPTH    = 2,
    parameter int STARVE_MAX = 4
) (
    input logic               clk,
    input logic               rst,
    wb_port_arbiter_if.slave  bus
);
    localparam int SW = $clog2(STARVE_MAX + 1);
    logic          a_need, b_push, b_full, b_empty, grant_a, grant_b;
    logic [SW-1:0] starve;
    wr_req_t       b_in, b_head;
    assign b_in = '{num: bus.b_rd_num_i, data: bus.b_rd_data_i};
    wb_arb_fifo #(.DEPTH(B_DEPTH)) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (b_push),
        .pop   (grant_b),
        .din   (b_in),
        .full  (b_full),
        .empty (b_empty),
        .head  (b_head)
    );
    // x0 writes from either port are accepted but never reach the register file
    always_comb begin
        a_need  = bus.a_v_i & bus.a_wb_i & (bus.a_rd_num_i != '0);
        b_push  = bus.b_v_i & ~b_full & (bus.b_rd_num_i != '0);
        grant_b = ~b_empty & (~a_need | (starve == SW'(STARVE_MAX)));
        grant_a = a_need & ~grant_b;
    end
    assign bus.a_stall_o = a_need & grant_b;
    assign bus.b_stall_o = b_full;
    assign bus.b_busy_o  = ~b_empty;
    always_ff @(posedge clk) begin
        if (rst) begin
            starve        <= '0;
            bus.wb_o      <= 1'b0;
            bus.wbr_num_o <= '0;
            bus.wb_data_o <= '0;
        end else begin
            starve        <= (b_empty | grant_b) ? '0 :
                             (starve == SW'(STARVE_MAX)) ? starve : starve + 1'b1;
            bus.wb_o      <= grant_a | grant_b;
            bus.wbr_num_o <= grant_b ? b_head.num  : grant_a ? bus.a_rd_num_i  : '0;
            bus.wb_data_o <= grant_b ? b_head.data : grant_a ? bus.a_rd_data_i : '0;
        end
    end
`ifdef WB_ARB_PERF_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            bus.perf_a_stall_o <= '0;
            bus.perf_b_full_o  <= '0;
        end else begin
            bus.perf_a_stall_o <= bus.perf_a_stall_o + 32'(bus.a_stall_o);
            bus.perf_b_full_o  <= bus.perf_b_full_o + 32'(bus.b_v_i & b_full);
        end
    end
`endif
endmodule
